// File: rtl/w5_mem_writer_pkg.sv
// Shared weight-memory definitions used by the writer and the reader cells.
package w_pkg;
    localparam int NBANK  = 16;
    localparam int DEPTH  = 16;
    localparam int DW     = 8;
    localparam int AW     = 4;
    localparam int NWORDS = NBANK * DEPTH;
    localparam int KW     = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        LOAD = 2'd2,
        FIN  = 2'd3
    } state_t;
endpackage

// File: rtl/w5_mem_writer_count256.sv
// Word counter for one kernel load: clear wins over enable, wraps at 256.
module count256
    import w_pkg::*;
(
    input  logic          clk,
    input  logic          xrst,
    input  logic          clr,
    input  logic          en,
    output logic [KW-1:0] k,
    output logic          last
);
    logic [KW-1:0] k_q, k_d;

    always_comb begin
        k_d = k_q;
        if (clr) begin
            k_d = '0;
        end else if (en) begin
            k_d = k_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (xrst) begin
            k_q <= '0;
        end else begin
            k_q <= k_d;
        end
    end

    assign k    = k_q;
    assign last = (k_q == KW'(NWORDS - 1));
endmodule

// File: rtl/w5_mem_writer.sv
// Streams one 256-word kernel into the 16 weight banks, bank index fastest.
// One-cycle registered write path; start is held off while readers are sweeping.
module w5_mem_writer #(
    parameter int NBANK = 16,
    parameter int DEPTH = 16,
    parameter int DW    = 8
) (
    input  logic             clk,
    input  logic             xrst,
    input  logic             start,
    input  logic             rd_busy,
    input  logic             s_valid,
    input  logic [DW-1:0]    s_data,
    output logic             s_ready,
    output logic [NBANK-1:0] wr_en,
    output logic [$clog2(DEPTH)-1:0] wr_addr,
    output logic [DW-1:0]    wr_data,
    output logic             busy,
    output logic             done,
    output logic             kernel_valid
);
    import w_pkg::*;

    localparam int BW = $clog2(NBANK);
    localparam int AWL = $clog2(DEPTH);

    state_t           state_q, state_d;
    logic             s_ready_q, s_ready_d;
    logic [NBANK-1:0] wr_en_q, wr_en_d;
    logic [AWL-1:0]   wr_addr_q, wr_addr_d;
    logic [DW-1:0]    wr_data_q, wr_data_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             kv_q, kv_d;

    logic [KW-1:0]    k;
    logic             k_last;
    logic             accept;
    logic             load_entry;
    logic             start_ok;

    count256 u_count (
        .clk  (clk),
        .xrst (xrst),
        .clr  (load_entry),
        .en   (accept),
        .k    (k),
        .last (k_last)
    );

    assign accept     = s_ready_q && s_valid;
    // The done cycle is already IDLE; a start landing on it belongs to the finished load.
    assign start_ok   = start && !done_q;
    assign load_entry = (state_d == LOAD) && (state_q != LOAD);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d = rd_busy ? WAIT : LOAD;
                end
            end
            WAIT: begin
                if (!rd_busy) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (accept && k_last) begin
                    state_d = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_en_d   = '0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (accept) begin
            wr_en_d   = NBANK'(1) << k[BW-1:0];
            wr_addr_d = k[BW +: AWL];
            wr_data_d = s_data;
        end
        s_ready_d = (state_d == LOAD);
        busy_d    = (state_d == WAIT) || (state_d == LOAD);
        done_d    = (state_q == FIN);
        kv_d      = kv_q;
        if (load_entry) begin
            kv_d = 1'b0;
        end else if (state_q == FIN) begin
            kv_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (xrst) begin
            state_q   <= IDLE;
            s_ready_q <= 1'b0;
            wr_en_q   <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            kv_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_ready_q <= s_ready_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            kv_q      <= kv_d;
        end
    end

    assign s_ready      = s_ready_q;
    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign kernel_valid = kv_q;
endmodule

// File: tb/tb_w5_mem_writer.sv
// Scoreboard bench for w5_mem_writer: driver queues expected writes, monitor checks them.
module tb_w5_mem_writer;
    logic        clk = 1'b0;
    logic        xrst, start, rd_busy, s_valid;
    logic [7:0]  s_data;
    logic        s_ready, busy, done, kernel_valid;
    logic [15:0] wr_en;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_data;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    logic [15:0] exp_q[$];
    logic [7:0]  mem[0:15][0:15];

    w5_mem_writer #(.NBANK(16), .DEPTH(16), .DW(8)) dut (
        .clk          (clk),
        .xrst         (xrst),
        .start        (start),
        .rd_busy      (rd_busy),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .busy         (busy),
        .done         (done),
        .kernel_valid (kernel_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int bank_of(input logic [15:0] v);
        for (int i = 0; i < 16; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic logic [7:0] pat(input int k, input int mode);
        int v;
        case (mode)
            0:       v = k - 128;
            1:       v = k * 7 + 3;
            default: v = ~k;
        endcase
        return v[7:0];
    endfunction

    // Monitor: every cycle, wr_en must be one-hot or zero; each write pops the scoreboard.
    always @(posedge clk) begin
        logic [15:0] e, got;
        int b;
        #1;
        check("wr_en_onehot0", 32'($onehot0(wr_en)), 32'd1);
        if (wr_en != 16'd0) begin
            wr_cnt++;
            b = bank_of(wr_en);
            mem[b][wr_addr] = wr_data;
            got = {b[3:0], wr_addr, wr_data};
            if (exp_q.size() == 0) begin
                check("spurious_write", got, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("write_bank_addr_data", got, e);
            end
        end
        if (done) done_cnt++;
    end

    task automatic check_reset_outs(input string tag);
        check({tag, "_s_ready"}, s_ready, 0);
        check({tag, "_wr_en"}, wr_en, 0);
        check({tag, "_wr_addr"}, wr_addr, 0);
        check({tag, "_wr_data"}, wr_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_kernel_valid"}, kernel_valid, 0);
    endtask

    task automatic begin_load(output int first);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_to_s_ready", s_ready, 1);
        check("load_busy", busy, 1);
        check("kv_cleared_on_load", kernel_valid, 0);
        first = cyc;
    endtask

    task automatic stream(input int first, input int last, input int mode, input int start_at);
        for (int k = first; k <= last; k++) begin
            logic [7:0] kk;
            int gap, guard;
            bit acc;
            kk = k[7:0];
            gap = 0;
            if (mode == 1) gap = (k == 16) ? 10 : int'($urandom_range(0, 3));
            repeat (gap) begin
                s_valid = 1'b0;
                s_data = 8'($urandom);
                @(posedge clk); #1;
            end
            s_valid = 1'b1;
            s_data = pat(k, mode);
            if (k == start_at) start = 1'b1;
            acc = 1'b0;
            guard = 0;
            while (!acc) begin
                @(negedge clk);
                if (s_ready) begin
                    acc = 1'b1;
                    exp_q.push_back({kk[3:0], kk[7:4], s_data});
                end
                @(posedge clk); #1;
                start = 1'b0;
                guard++;
                if (!acc && guard > 20) begin
                    check("stream_accept_timeout", 0, 1);
                    s_valid = 1'b0;
                    return;
                end
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_done(input int first, input int exp_len);
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (done) begin
                if (exp_len > 0) check("done_latency", cyc - first + 1, exp_len);
                check("kv_set_with_done", kernel_valid, 1);
                return;
            end
        end
        check("done_timeout", 0, 1);
    endtask

    task automatic check_fin_cycle();
        check("fin_s_ready", s_ready, 0);
        check("fin_wr_en", wr_en, 16'h8000);
        check("fin_wr_addr", wr_addr, 4'd15);
    endtask

    initial begin
        int first, w0, d0;
        xrst = 1'b1; start = 1'b0; rd_busy = 1'b0; s_valid = 1'b0; s_data = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outs("reset");
        xrst = 1'b0;
        @(posedge clk); #1;

        // Back-to-back load, data = k-128.
        w0 = wr_cnt; d0 = done_cnt;
        begin_load(first);
        stream(0, 255, 0, -1);
        check_fin_cycle();
        wait_done(first, 258);
        repeat (4) @(posedge clk);
        #1;
        check("load1_done_once", done_cnt - d0, 1);
        check("load1_writes", wr_cnt - w0, 256);
        check("load1_queue_empty", exp_q.size(), 0);
        check("bank5_addr3", mem[5][3], 8'hB5);
        check("load1_kv_after", kernel_valid, 1);

        // Second kernel with random gaps, including a 10-cycle stall after word 15.
        w0 = wr_cnt; d0 = done_cnt;
        begin_load(first);
        stream(0, 255, 1, -1);
        check_fin_cycle();
        wait_done(first, 0);
        repeat (3) @(posedge clk);
        #1;
        check("load2_done_once", done_cnt - d0, 1);
        check("load2_writes", wr_cnt - w0, 256);
        check("load2_queue_empty", exp_q.size(), 0);
        check("load2_kv_after", kernel_valid, 1);

        // Interlock: readers busy for 7 cycles, then start pulses in LOAD, FIN and done cycles.
        w0 = wr_cnt; d0 = done_cnt;
        rd_busy = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            check("wait_busy", busy, 1);
            check("wait_s_ready", s_ready, 0);
        end
        rd_busy = 1'b0;
        @(posedge clk); #1;
        check("ready_after_rd_busy_low", s_ready, 1);
        check("wait_kv_cleared", kernel_valid, 0);
        first = cyc;
        rd_busy = 1'b1;
        stream(0, 255, 2, 40);
        rd_busy = 1'b0;
        check_fin_cycle();
        start = 1'b1;
        @(posedge clk); #1;
        check("load3_done", done, 1);
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("no_second_load_ready", s_ready, 0);
            check("no_second_load_busy", busy, 0);
            @(posedge clk); #1;
        end
        check("load3_done_once", done_cnt - d0, 1);
        check("load3_writes", wr_cnt - w0, 256);
        check("load3_queue_empty", exp_q.size(), 0);

        // Reset after word 100, then a fresh load must restart at bank 0, address 0.
        begin_load(first);
        stream(0, 100, 0, -1);
        xrst = 1'b1;
        @(posedge clk); #1;
        check_reset_outs("midload_reset");
        check("midload_queue_empty", exp_q.size(), 0);
        xrst = 1'b0;
        @(posedge clk); #1;
        w0 = wr_cnt; d0 = done_cnt;
        begin_load(first);
        stream(0, 255, 0, -1);
        check_fin_cycle();
        wait_done(first, 258);
        repeat (3) @(posedge clk);
        #1;
        check("load4_done_once", done_cnt - d0, 1);
        check("load4_writes", wr_cnt - w0, 256);
        check("load4_queue_empty", exp_q.size(), 0);
        check("load4_kv_after", kernel_valid, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
